t_updown_counter: RTL

T_UPDOWN_COUNTER -- requirements
Module: t_updown_counter

---
 rtl/counter_pkg.sv | 10 +
 rtl/t_flip_flop_r.sv | 17 +
 rtl/t_updown_counter.sv | 89 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Constants shared by the up/down counter and its bench: count direction
// encoding and the default counter width.
package counter_pkg;

    localparam bit DIR_UP   = 1'b1;
    localparam bit DIR_DOWN = 1'b0;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/t_flip_flop_r.sv
// Single T flip-flop with asynchronous active-low reset; one per count bit.
module t_flip_flop_r (
    input  logic clk,
    input  logic rst_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/t_updown_counter.sv
// Up/down counter built from a chain of T flip-flops, with load clamping,
// wrap-or-saturate boundaries, a cascade flag and sticky boundary tracking.
module t_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}},
    parameter int               SATURATE  = 0
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    input  logic             Clr_ovf,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             Wrap,
    output logic             Ovf
);

    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count_next;
    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t_vec;
    logic             at_top;
    logic             at_bottom;
    logic             boundary_evt;

    assign at_top    = (Q == MAX_COUNT);
    assign at_bottom = (Q == '0);

    // Out-of-range load values are clamped silently; they are not boundary events.
    assign load_val = (D > MAX_COUNT) ? MAX_COUNT : D;

    always_comb begin
        count_next = Q;
        if (Up == DIR_UP) begin
            if (!at_top) begin
                count_next = Q + 1'b1;
            end else if (SATURATE == 0) begin
                count_next = '0;
            end
        end else begin
            if (!at_bottom) begin
                count_next = Q - 1'b1;
            end else if (SATURATE == 0) begin
                count_next = MAX_COUNT;
            end
        end
    end

    always_comb begin
        next_q = Q;
        if (Load) begin
            next_q = load_val;
        end else if (En) begin
            next_q = count_next;
        end
    end

    // Each bit toggles exactly where the desired next value differs from now.
    assign t_vec = next_q ^ Q;

    assign TC           = En & ((Up == DIR_UP) ? at_top : at_bottom);
    assign boundary_evt = TC & ~Load;

    for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        t_flip_flop_r u_tff (
            .clk   (CLK),
            .rst_n (Reset),
            .t     (t_vec[i]),
            .q     (Q[i])
        );
    end

    // A new boundary event outranks a simultaneous clear of the sticky flag.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            Wrap <= 1'b0;
            Ovf  <= 1'b0;
        end else begin
            Wrap <= boundary_evt;
            Ovf  <= boundary_evt | (Ovf & ~Clr_ovf);
        end
    end

endmodule
